// File: rtl/bcd_to_binary_pkg.sv
// Shared widths, limits and FSM encoding for the BCD-to-binary converter.
package bcd_to_binary_pkg;

    localparam int BCD_DIGIT_W   = 4;
    localparam int BIN_W         = 7;
    localparam int SHIFT_STEPS   = 7;
    localparam int BCD_MAX_DIGIT = 9;
    localparam int CNT_W         = 3;
    localparam int SCRATCH_W     = 2 * BCD_DIGIT_W + BIN_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic digit_invalid(input logic [BCD_DIGIT_W-1:0] d);
        return d > BCD_DIGIT_W'(BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Reverse double-dabble correction for one BCD digit: undo the +3 bias
// once a shifted digit has reached 8 or more.
module bcd_digit_adjust
    import bcd_to_binary_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d_i,
    output logic [BCD_DIGIT_W-1:0] d_o
);

    assign d_o = (d_i >= BCD_DIGIT_W'(8)) ? d_i - BCD_DIGIT_W'(3) : d_i;

endmodule

// File: rtl/bcd_to_binary.sv
// Two-digit BCD to 7-bit binary converter using a serial reverse
// double-dabble over seven shift steps, with clock enable and error flagging.
module bcd_to_binary
    import bcd_to_binary_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   i_start,
    input  logic [BCD_DIGIT_W-1:0] i_bcd_msb,
    input  logic [BCD_DIGIT_W-1:0] i_bcd_lsb,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_error,
    output logic [BIN_W-1:0]       o_binary
);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SCRATCH_W-1:0] scratch_q, scratch_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic [BIN_W-1:0]     binary_q, binary_d;

    logic [SCRATCH_W-1:0]   shifted;
    logic [SCRATCH_W-1:0]   shift_next;
    logic [BCD_DIGIT_W-1:0] adj_msb, adj_lsb;
    logic                   accept;
    logic                   digits_bad;

    assign shifted    = scratch_q >> 1;
    assign digits_bad = digit_invalid(i_bcd_msb) || digit_invalid(i_bcd_lsb);
    // A start coinciding with the o_done pulse is dropped, not deferred.
    assign accept     = i_start && !done_q;

    bcd_digit_adjust u_adj_msb (
        .d_i (shifted[SCRATCH_W-1 -: BCD_DIGIT_W]),
        .d_o (adj_msb)
    );

    bcd_digit_adjust u_adj_lsb (
        .d_i (shifted[BIN_W +: BCD_DIGIT_W]),
        .d_o (adj_lsb)
    );

    assign shift_next = {adj_msb, adj_lsb, shifted[BIN_W-1:0]};

    // State register; ena gates every state update, including the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            scratch_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            binary_q  <= '0;
        end else if (ena) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            scratch_q <= scratch_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            binary_q  <= binary_d;
        end
    end

    always_comb begin
        // NOTE: default assignment first, so no path through the case leaves
        // state_d unassigned and infers a latch.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept) state_d = digits_bad ? ST_DONE : ST_SHIFT;
            ST_SHIFT: if (cnt_q == CNT_W'(SHIFT_STEPS - 1)) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        scratch_d = scratch_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = error_q;
        binary_d  = binary_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    scratch_d = {i_bcd_msb, i_bcd_lsb, {BIN_W{1'b0}}};
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    error_d   = digits_bad;
                    if (digits_bad) binary_d = '0;
                end
            end
            ST_SHIFT: begin
                scratch_d = shift_next;
                cnt_d     = cnt_q + CNT_W'(1);
            end
            ST_DONE: begin
                binary_d = error_q ? '0 : scratch_q[BIN_W-1:0];
                done_d   = 1'b1;
                busy_d   = 1'b0;
            end
            default: ;
        endcase
    end

    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_error  = error_q;
    assign o_binary = binary_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed self-checking bench for bcd_to_binary: inputs change and outputs
// are sampled on the falling edge, away from the active rising edge.
module tb_bcd_to_binary;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       i_start = 1'b0;
    logic [3:0] i_bcd_msb = 4'd0;
    logic [3:0] i_bcd_lsb = 4'd0;
    logic       o_busy;
    logic       o_done;
    logic       o_error;
    logic [6:0] o_binary;

    int checks = 0;
    int errors = 0;

    bcd_to_binary dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .i_start   (i_start),
        .i_bcd_msb (i_bcd_msb),
        .i_bcd_lsb (i_bcd_lsb),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_error   (o_error),
        .o_binary  (o_binary)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // Called on a falling edge; returns on the falling edge after the start edge.
    task automatic issue_start(input logic [3:0] m, input logic [3:0] l);
        i_bcd_msb = m;
        i_bcd_lsb = l;
        i_start   = 1'b1;
        @(negedge clk);
        i_start   = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (o_done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        ena   = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_busy, o_done, o_error} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got busy/done/err=%b expected 000", {o_busy, o_done, o_error});
        end
        checks++;
        if (o_binary !== 7'd0) begin
            errors++;
            $display("FAIL reset_binary: got %0d expected 0", o_binary);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got busy=%b expected 0", o_busy);
        end
    endtask

    task automatic test_basic;
        issue_start(4'd5, 4'd9);
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (o_busy !== 1'b1 || o_done !== 1'b0) begin
                errors++;
                $display("FAIL basic_busy_k+%0d: got busy=%b done=%b expected busy=1 done=0", j, o_busy, o_done);
            end
            @(negedge clk);
        end
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_k+8: got done=%b busy=%b expected done=1 busy=0", o_done, o_busy);
        end
        checks++;
        if (o_binary !== 7'h3B || o_error !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got %0d err=%b expected 59 err=0", o_binary, o_error);
        end
        @(negedge clk);
        checks++;
        if (o_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse_width: got done=%b expected 0", o_done);
        end
    endtask

    task automatic test_sweep;
        int lat;
        logic [6:0] exp_bin;
        for (int m = 0; m < 10; m++) begin
            for (int l = 0; l < 10; l++) begin
                exp_bin = 7'(m * 10 + l);
                issue_start(4'(m), 4'(l));
                wait_done(lat);
                checks++;
                if (o_binary !== exp_bin || lat != 8 || o_error !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep_%0d%0d: got bin=%0d lat=%0d err=%b expected bin=%0d lat=8 err=0",
                             m, l, o_binary, lat, o_error, exp_bin);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_start_during_done;
        int lat;
        issue_start(4'd2, 4'd6);
        wait_done(lat);
        issue_start(4'd3, 4'd3);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL start_during_done_ignored: got busy=%b expected 0", o_busy);
        end
        issue_start(4'd3, 4'd3);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL start_after_done_accepted: got busy=%b expected 1", o_busy);
        end
        wait_done(lat);
        checks++;
        if (o_binary !== 7'd33 || lat != 8) begin
            errors++;
            $display("FAIL start_after_done_result: got bin=%0d lat=%0d expected bin=33 lat=8", o_binary, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_error;
        int lat;
        issue_start(4'hA, 4'd5);
        checks++;
        if (o_error !== 1'b1 || o_binary !== 7'd0 || o_done !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL error_at_k: got err=%b bin=%0d done=%b busy=%b expected err=1 bin=0 done=0 busy=1",
                     o_error, o_binary, o_done, o_busy);
        end
        @(negedge clk);
        checks++;
        if (o_done !== 1'b1 || o_error !== 1'b1 || o_binary !== 7'd0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL error_done_k+1: got done=%b err=%b bin=%0d busy=%b expected done=1 err=1 bin=0 busy=0",
                     o_done, o_error, o_binary, o_busy);
        end
        @(negedge clk);
        checks++;
        if (o_done !== 1'b0 || o_error !== 1'b1) begin
            errors++;
            $display("FAIL error_hold: got done=%b err=%b expected done=0 err=1", o_done, o_error);
        end
        issue_start(4'd0, 4'd7);
        checks++;
        if (o_error !== 1'b0) begin
            errors++;
            $display("FAIL error_clear_on_start: got err=%b expected 0", o_error);
        end
        wait_done(lat);
        checks++;
        if (o_binary !== 7'd7 || lat != 8) begin
            errors++;
            $display("FAIL error_recovery_result: got bin=%0d lat=%0d expected bin=7 lat=8", o_binary, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_restart;
        int lat;
        issue_start(4'd9, 4'd9);
        @(negedge clk);
        @(negedge clk);
        i_bcd_msb = 4'd1;
        i_bcd_lsb = 4'd2;
        i_start   = 1'b1;
        @(negedge clk);
        i_start   = 1'b0;
        i_bcd_msb = 4'd3;
        i_bcd_lsb = 4'd4;
        wait_done(lat);
        checks++;
        if (o_binary !== 7'd99 || lat + 3 != 8) begin
            errors++;
            $display("FAIL ignore_restart_result: got bin=%0d lat=%0d expected bin=99 lat=8", o_binary, lat + 3);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL ignore_restart_no_queue: got busy=%b done=%b expected 0 0", o_busy, o_done);
        end
    endtask

    task automatic test_enable_stall;
        int lat;
        issue_start(4'd4, 4'd2);
        @(negedge clk);
        ena = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (o_busy !== 1'b1 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: got busy=%b done=%b expected busy=1 done=0", o_busy, o_done);
        end
        ena = 1'b1;
        wait_done(lat);
        checks++;
        if (o_binary !== 7'd42 || lat + 4 != 11) begin
            errors++;
            $display("FAIL stall_result: got bin=%0d lat=%0d expected bin=42 lat=11", o_binary, lat + 4);
        end
        ena = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (o_done !== 1'b1) begin
            errors++;
            $display("FAIL stall_done_hold: got done=%b expected 1", o_done);
        end
        ena = 1'b1;
        @(negedge clk);
        checks++;
        if (o_done !== 1'b0) begin
            errors++;
            $display("FAIL stall_done_release: got done=%b expected 0", o_done);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        int seen_done;
        issue_start(4'd8, 4'd8);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_done, o_error} !== 3'b000 || o_binary !== 7'd0) begin
            errors++;
            $display("FAIL reset_mid_async: got busy/done/err=%b bin=%0d expected 000 bin=0",
                     {o_busy, o_done, o_error}, o_binary);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (o_done === 1'b1 || o_busy === 1'b1) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL reset_mid_no_done: got %0d active cycles expected 0", seen_done);
        end
        issue_start(4'd1, 4'd0);
        wait_done(lat);
        checks++;
        if (o_binary !== 7'd10 || lat != 8 || o_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_recovery: got bin=%0d lat=%0d err=%b expected bin=10 lat=8 err=0",
                     o_binary, lat, o_error);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sweep();
        test_start_during_done();
        test_error();
        test_ignore_restart();
        test_enable_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
